// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns one at a time, debounces whole-scan results,
// and shifts each accepted key code into a 32-bit nibble register.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] value
);

    typedef enum logic [1:0] {StIdle, StCand, StPressed, StRelease} state_e;

    logic [3:0]  row_s1_q, row_s2_q;
    logic [31:0] slot_cnt_q;
    logic [1:0]  col_idx_q;
    logic [11:0] scan_q;
    logic        slot_end, scan_end;
    logic [15:0] scan_full;
    logic [4:0]  hit_cnt;
    logic [3:0]  hit_code;
    logic        no_key, one_key;

    state_e      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [31:0] deb_q, deb_d;
    logic        accept;

    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic [31:0] value_q;

    // Bit c*4+r of a scan vector is set when the key at row r, column c is pressed.
    function automatic logic [3:0] code_of(input logic [3:0] idx);
        logic [3:0] code;
        unique case (idx)
            4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
            4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
            4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
            4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign slot_end  = (slot_cnt_q == SCAN_DIV - 1);
    assign scan_end  = slot_end && (col_idx_q == 2'd3);
    // Column 3 is classified straight from the synchronizer in its sampling cycle.
    assign scan_full = {~row_s2_q, scan_q};

    always_comb begin
        hit_cnt  = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_full[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = code_of(4'(i));
            end
        end
    end

    assign no_key  = (hit_cnt == 5'd0);
    assign one_key = (hit_cnt == 5'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            slot_cnt_q <= '0;
            col_idx_q  <= '0;
            scan_q     <= '0;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
            if (slot_end) begin
                slot_cnt_q <= '0;
                col_idx_q  <= col_idx_q + 2'd1;
                unique case (col_idx_q)
                    2'd0:    scan_q[3:0]  <= ~row_s2_q;
                    2'd1:    scan_q[7:4]  <= ~row_s2_q;
                    2'd2:    scan_q[11:8] <= ~row_s2_q;
                    default: ;
                endcase
            end else begin
                slot_cnt_q <= slot_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        accept  = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                StIdle: begin
                    if (one_key) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = StPressed;
                        end else begin
                            state_d = StCand;
                            cand_d  = hit_code;
                            deb_d   = 32'd1;
                        end
                    end
                end
                StCand: begin
                    if (one_key && hit_code == cand_q) begin
                        if (deb_q + 32'd1 >= DEBOUNCE_SCANS) begin
                            accept  = 1'b1;
                            state_d = StPressed;
                        end else begin
                            deb_d = deb_q + 32'd1;
                        end
                    end else if (one_key) begin
                        cand_d = hit_code;
                        deb_d  = 32'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPressed: begin
                    if (no_key) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StRelease;
                            deb_d   = 32'd1;
                        end
                    end
                end
                StRelease: begin
                    if (!no_key) begin
                        state_d = StPressed;
                    end else if (deb_q + 32'd1 >= DEBOUNCE_SCANS) begin
                        state_d = StIdle;
                    end else begin
                        deb_d = deb_q + 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cand_q      <= '0;
            deb_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            deb_q       <= deb_d;
            key_valid_q <= accept;
            if (accept) key_code_q <= hit_code;
            // clear takes priority over a coincident accept.
            if (clear) value_q <= '0;
            else if (accept) value_q <= {value_q[27:0], hit_code};
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = (state_q == StPressed) || (state_q == StRelease);
    assign value     = value_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix hex keypad and turns debounced key presses into hex digits. It is the input-side counterpart of the multiplexed 7-segment display driver: it time-multiplexes column drive outward and reads row lines back inward. Each accepted press shifts one nibble into a 32-bit value register, which the processor's I/O space reads and the display driver can show directly.

## Interface

Parameters:
- SCAN_DIV, default 100000: clock cycles per column slot (1 ms at 100 MHz); must be at least 4.
- DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release; must be at least 1.

Ports:
- clk, input, 1: the single clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- row, input, 4: keypad rows, active-low (pulled up); asynchronous to clk.
- clear, input, 1: synchronous; zeroes value.
- col, output, 4: column drive, active-low, exactly one bit low at a time.
- key_valid, output, 1: one-cycle pulse when a press is accepted.
- key_code, output, 4: code of the last accepted key; held between presses.
- key_held, output, 1: high while an accepted key has not yet been debounced as released.
- value, output, 32: nibble shift register of accepted keys, newest key in [3:0].

## Operation

- Reset values: col=4'b1110, key_valid=0, key_code=0, key_held=0, value=0. Slot counter=0, column index=0, FSM=IDLE.
- Row input path: a 2-flop synchronizer feeds the row sampler.
- Slot counter runs 0..SCAN_DIV-1. On the wrap, the column index advances 0→1→2→3→0. col is the active-low one-hot of the column index.
- On the last cycle of each slot (count=SCAN_DIV-1), the synchronized row value is sampled for the current column.
- One full scan is columns 0..3. At the end of column 3's slot, the scan result is classified:
  - NONE: no key pressed.
  - SINGLE(K): exactly one key pressed, with code K.
  - MULTI: more than one key pressed.
- Key map (row r, column c → code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- The FSM is evaluated only at end-of-scan:
  - IDLE:
    - SINGLE(K) → CAND, with cand=K, cnt=1.
    - Otherwise stay in IDLE.
    - If DEBOUNCE_SCANS=1, SINGLE(K) accepts K immediately and goes to PRESSED.
  - CAND:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - SINGLE(other K) → restart with cand=K, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE, with cnt=1 (or IDLE directly if DEBOUNCE_SCANS=1).
    - Otherwise stay in PRESSED. There is no auto-repeat, and roll-over to a second key is ignored.
  - RELEASE:
    - NONE → cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - SINGLE or MULTI → PRESSED.
- Accept action, on the cycle after the end-of-scan edge:
  - key_valid=1 for exactly one cycle.
  - key_code=K.
  - value={value[27:0],K}. The top nibble is discarded, so the register wraps after 8 keys.
- key_held=1 in PRESSED and RELEASE; 0 in IDLE and CAND.
- clear:
  - clear=1 sets value=0 on the next edge.
  - If clear coincides with an accept, clear wins: value=0. key_valid and key_code still update.
  - clear does not affect the FSM or the scan.
- Reset asserted mid-scan or mid-debounce: everything returns immediately to reset values. No pulse is emitted.

## Timing

- col changes on the clock edge after count=SCAN_DIV-1, so each column stays low for exactly SCAN_DIV cycles.
- The scan period is 4*SCAN_DIV cycles.
- Row settling: row must be stable at least 3 cycles before the slot's last cycle (2 synchronizer stages plus sample). The minimum SCAN_DIV of 4 enforces this.
- Press latency: a key held stably from the start of a scan produces key_valid 1 cycle after the end of scan number DEBOUNCE_SCANS. That is DEBOUNCE_SCANS*4*SCAN_DIV+1 cycles after the start of that first scan, plus up to one scan of misalignment.
- key_held rises in the same cycle as key_valid. It falls 1 cycle after the DEBOUNCE_SCANS-th consecutive NONE scan.
- value and key_code are registered; they change only in the cycle where key_valid=1, or one cycle after clear.

## Test plan

Unless stated otherwise, tests use SCAN_DIV=4 and DEBOUNCE_SCANS=2 (scan period 16 cycles). The bench models a keypad that pulls a row low when that row's column is low and the key is pressed.

- Reset: hold reset=0 for 5 cycles → col=1110, value=0, key_valid=0, key_held=0. Release reset → col sequence 1110, 1101, 1011, 0111, each for 4 cycles, then back to 1110.
- Single press: hold key "5" (r1, c1) for 6 scans → exactly one key_valid pulse, key_code=5, value=0x00000005. key_held stays high until 2 scans after release.
- Sequence and wrap: press and release keys 1,2,3,4,5,6,7,8,9 → value=0x23456789 after the ninth press; 9 key_valid pulses total.
- Bounce: key "A" toggles every scan for 5 scans, then stays pressed → no pulse during the toggling; one pulse, key_code=A, after 2 stable scans.
- Multi-key and roll-over: press "1" and "2" together from IDLE → no pulse. Press "3", accept it, then add "4" while "3" is still held → no second pulse.
- clear and reset conflicts: assert clear in the exact cycle key_valid pulses for "F" → value=0, key_code=F. Assert reset=0 midway through CAND → no pulse, all outputs at reset values.
